// File: rtl/chi_steer_pkg.sv
// Shared definitions for the chi steering loop and coupling_susceptibility.
// Position class encodings, steering FSM states and the Q14 unity constant.
package chi_steer_pkg;

    localparam logic [1:0] CLS_ATTRACTOR = 2'b00;
    localparam logic [1:0] CLS_BOUNDARY  = 2'b01;
    localparam logic [1:0] CLS_QUARTER   = 2'b10;
    localparam logic [1:0] CLS_HOLD      = 2'b11;

    localparam int ONE = 16384;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } steer_state_t;

endpackage

// File: rtl/chi_steer_step.sv
// Per-oscillator hill-climb step: direction flip on rising chi, signed
// step by position class, saturation into [OMEGA_MIN, OMEGA_MAX].
module chi_steer_step
    import chi_steer_pkg::*;
#(
    parameter int WIDTH     = 18,
    parameter int STEP      = 64,
    parameter int OMEGA_MIN = 1024,
    parameter int OMEGA_MAX = 98304
) (
    input  logic signed [WIDTH-1:0] i_omega,
    input  logic signed [WIDTH-1:0] i_chi,
    input  logic signed [WIDTH-1:0] i_last_chi,
    input  logic                    i_valid,
    input  logic                    i_dir,
    input  logic [1:0]              i_cls,
    output logic signed [WIDTH-1:0] o_omega,
    output logic                    o_dir,
    output logic                    o_adj
);

    localparam logic signed [WIDTH:0] P_FULL = (WIDTH+1)'(STEP);
    localparam logic signed [WIDTH:0] P_HALF = (WIDTH+1)'(STEP / 2);
    localparam logic signed [WIDTH:0] P_LO   = (WIDTH+1)'(OMEGA_MIN);
    localparam logic signed [WIDTH:0] P_HI   = (WIDTH+1)'(OMEGA_MAX);

    logic signed [WIDTH:0] w_step;
    logic signed [WIDTH:0] w_sum;
    logic                  w_act;
    logic                  w_dir;

    // Pick step from class, flip direction if chi rose, add in WIDTH+1 bits and clamp
    always_comb begin
        w_step  = '0;
        w_act   = 1'b0;
        unique case (i_cls)
            CLS_BOUNDARY: begin
                w_step = P_FULL;
                w_act  = 1'b1;
            end
            CLS_QUARTER: begin
                w_step = P_HALF;
                w_act  = 1'b1;
            end
            default: begin
                w_step = '0;
                w_act  = 1'b0;
            end
        endcase
        w_dir = i_dir ^ (w_act && i_valid && (i_chi > i_last_chi));
        w_sum = {i_omega[WIDTH-1], i_omega} + (w_dir ? w_step : -w_step);
        if (!w_act) begin
            o_omega = i_omega;
        end else if (w_sum > P_HI) begin
            o_omega = P_HI[WIDTH-1:0];
        end else if (w_sum < P_LO) begin
            o_omega = P_LO[WIDTH-1:0];
        end else begin
            o_omega = w_sum[WIDTH-1:0];
        end
        o_dir = w_dir;
        o_adj = w_act;
    end

endmodule

// File: rtl/chi_steering_controller.sv
// Closed-loop omega_dt steering from chi measurements, one oscillator per cycle.
// Optional CHI_STEER_AUTOSTOP_EN: end the run when a sweep makes no adjustment.
module chi_steering_controller
    import chi_steer_pkg::*;
#(
    parameter int WIDTH           = 18,
    parameter int FRAC            = 14,
    parameter int NUM_OSCILLATORS = 21,
    parameter int STEP            = 64,
    parameter int OMEGA_MIN       = 1024,
    parameter int OMEGA_MAX       = 98304,
    parameter int SETTLE_CYCLES   = 6,
    parameter int MAX_SWEEPS      = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clk_en,
    input  logic                               start,
    input  logic                               abort,
    input  logic [NUM_OSCILLATORS*WIDTH-1:0]   omega_dt_init_packed,
    input  logic [NUM_OSCILLATORS*WIDTH-1:0]   chi_packed,
    input  logic [NUM_OSCILLATORS*2-1:0]       position_class_packed,
    output logic [NUM_OSCILLATORS*WIDTH-1:0]   omega_dt_packed,
    output logic                               busy,
    output logic                               done,
    output logic                               converged,
    output logic [7:0]                         sweep_count,
    output logic [4:0]                         adj_count
);

    localparam int IDX_W = $clog2(NUM_OSCILLATORS);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OSCILLATORS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       SWP_LAST = 8'(MAX_SWEEPS);

    steer_state_t            r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [WIDTH-1:0] r_omega    [NUM_OSCILLATORS];
    logic signed [WIDTH-1:0] r_last_chi [NUM_OSCILLATORS];
    logic [NUM_OSCILLATORS-1:0] r_valid;
    logic [NUM_OSCILLATORS-1:0] r_dir;
    logic                    r_done;
    logic                    r_conv;
    logic [7:0]              r_sweeps;
    logic [4:0]              r_adj;

    logic signed [WIDTH-1:0] w_chi;
    logic [1:0]              w_cls;
    logic signed [WIDTH-1:0] w_new_omega;
    logic                    w_new_dir;
    logic                    w_adj;
    logic [7:0]              w_sweeps_nxt;

    assign w_chi        = chi_packed[int'(r_idx)*WIDTH +: WIDTH];
    assign w_cls        = position_class_packed[int'(r_idx)*2 +: 2];
    assign w_sweeps_nxt = r_sweeps + 8'd1;

    chi_steer_step #(
        .WIDTH     (WIDTH),
        .STEP      (STEP),
        .OMEGA_MIN (OMEGA_MIN),
        .OMEGA_MAX (OMEGA_MAX)
    ) u_step (
        .i_omega    (r_omega[r_idx]),
        .i_chi      (w_chi),
        .i_last_chi (r_last_chi[r_idx]),
        .i_valid    (r_valid[r_idx]),
        .i_dir      (r_dir[r_idx]),
        .i_cls      (w_cls),
        .o_omega    (w_new_omega),
        .o_dir      (w_new_dir),
        .o_adj      (w_adj)
    );

    // Sweep FSM: load seeds, visit one oscillator per cycle, settle, repeat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_valid  <= '0;
            r_dir    <= '1;
            r_done   <= 1'b0;
            r_conv   <= 1'b0;
            r_sweeps <= '0;
            r_adj    <= '0;
            for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                r_omega[i]    <= '0;
                r_last_chi[i] <= '0;
            end
        end else if (clk_en) begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state  <= ST_SCAN;
                        r_idx    <= '0;
                        r_adj    <= '0;
                        r_sweeps <= '0;
                        r_conv   <= 1'b0;
                        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
                            r_omega[i] <= omega_dt_init_packed[i*WIDTH +: WIDTH];
                        end
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_omega[r_idx]    <= w_new_omega;
                        r_dir[r_idx]      <= w_new_dir;
                        r_last_chi[r_idx] <= w_chi;
                        r_valid[r_idx]    <= 1'b1;
                        if (w_adj) begin
                            r_adj <= r_adj + 5'd1;
                        end
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_sweeps <= w_sweeps_nxt;
                        if (w_sweeps_nxt == SWP_LAST) begin
                            r_state <= ST_DONE;
`ifdef CHI_STEER_AUTOSTOP_EN
                        end else if (r_adj == 5'd0) begin
                            r_state <= ST_DONE;
                            r_conv  <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_SCAN;
                            r_idx   <= '0;
                            r_adj   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_OSCILLATORS; g++) begin : g_pack
        assign omega_dt_packed[g*WIDTH +: WIDTH] = r_omega[g];
    end

    assign busy        = (r_state == ST_SCAN) || (r_state == ST_SETTLE);
    assign done        = r_done;
    assign converged   = r_conv;
    assign sweep_count = r_sweeps;
    assign adj_count   = r_adj;

endmodule

// File: tb/tb_chi_steering_controller.sv
// Scoreboard bench for chi_steering_controller: expectations are queued by
// target cycle and a negedge monitor compares them against the DUT outputs.
module tb_chi_steering_controller;

    localparam int W = 18;
    localparam int N = 21;

    localparam int K_OMEGA = 0;
    localparam int K_BUSY  = 1;
    localparam int K_DONE  = 2;
    localparam int K_SWEEP = 3;
    localparam int K_ADJ   = 4;
    localparam int K_CONV  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clk_en = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [N*W-1:0]   omega_dt_init_packed = '0;
    logic [N*W-1:0]   chi_packed = '0;
    logic [N*2-1:0]   position_class_packed = '0;
    logic [N*W-1:0]   omega_dt_packed;
    logic             busy;
    logic             done;
    logic             converged;
    logic [7:0]       sweep_count;
    logic [4:0]       adj_count;

    typedef struct {
        int    cyc;
        int    kind;
        int    idx;
        int    exp;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   s;

    chi_steering_controller dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .clk_en                (clk_en),
        .start                 (start),
        .abort                 (abort),
        .omega_dt_init_packed  (omega_dt_init_packed),
        .chi_packed            (chi_packed),
        .position_class_packed (position_class_packed),
        .omega_dt_packed       (omega_dt_packed),
        .busy                  (busy),
        .done                  (done),
        .converged             (converged),
        .sweep_count           (sweep_count),
        .adj_count             (adj_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    function automatic int actual(int kind, int idx);
        logic signed [W-1:0] v;
        v = omega_dt_packed[idx*W +: W];
        case (kind)
            K_OMEGA: return int'(v);
            K_BUSY:  return int'(busy);
            K_DONE:  return int'(done);
            K_SWEEP: return int'(sweep_count);
            K_ADJ:   return int'(adj_count);
            K_CONV:  return int'(converged);
            default: return -1;
        endcase
    endfunction

    task automatic expect_at(int c, int kind, int idx, int exp, string name);
        exp_t e;
        int   p;
        e.cyc  = c;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        e.name = name;
        p = q.size();
        while (p > 0 && q[p-1].cyc > c) p--;
        q.insert(p, e);
    endtask

    // monitor: compare every expectation whose cycle has come up
    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc)
                check({e.name, "_missed"}, cyc, e.cyc);
            else
                check(e.name, actual(e.kind, e.idx), e.exp);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic until_cyc(int c);
        while (cyc < c) tick(1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (q.size() > 0 && b < 200) begin
            tick(1);
            b++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        clk_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic set_all(int seed, int c, int x);
        for (int i = 0; i < N; i++) begin
            omega_dt_init_packed[i*W +: W] = W'(seed);
            position_class_packed[i*2 +: 2] = 2'(c);
            chi_packed[i*W +: W] = W'(x);
        end
    endtask

    task automatic set_osc(int i, int seed, int c, int x);
        omega_dt_init_packed[i*W +: W] = W'(seed);
        position_class_packed[i*2 +: 2] = 2'(c);
        chi_packed[i*W +: W] = W'(x);
    endtask

    task automatic go(output int st);
        st = cyc + 1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_all(16384, 0, 0);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_omega_any", int'(|omega_dt_packed), 0);
        check("rst_sweep", int'(sweep_count), 0);
        check("rst_conv", int'(converged), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // all attractor: one sweep, nothing adjusted
        set_all(16384, 0, 0);
        go(s);
        expect_at(s + 1,  K_BUSY,  0, 1,     "t2_busy");
        expect_at(s + 22, K_ADJ,   0, 0,     "t2_adj");
        expect_at(s + 22, K_OMEGA, 0, 16384, "t2_om0");
        expect_at(s + 22, K_OMEGA, 20, 16384, "t2_om20");
`ifdef CHI_STEER_AUTOSTOP_EN
        expect_at(s + 27, K_BUSY,  0, 0, "t2_busy_done");
        expect_at(s + 27, K_DONE,  0, 0, "t2_done_early");
        expect_at(s + 28, K_DONE,  0, 1, "t2_done");
        expect_at(s + 28, K_CONV,  0, 1, "t2_conv");
        expect_at(s + 28, K_SWEEP, 0, 1, "t2_sweep");
        expect_at(s + 29, K_DONE,  0, 0, "t2_done_end");
        until_cyc(s + 31);
`else
        expect_at(s + 27, K_SWEEP, 0, 1, "t2_sweep");
        expect_at(s + 27, K_BUSY,  0, 1, "t2_busy_rescan");
        expect_at(s + 28, K_CONV,  0, 0, "t2_conv");
        expect_at(s + 30, K_DONE,  0, 1, "t2_abort_done");
        expect_at(s + 30, K_BUSY,  0, 0, "t2_abort_busy");
        expect_at(s + 31, K_DONE,  0, 0, "t2_done_end");
        until_cyc(s + 29);
        pulse_abort();
`endif
        drain();

        // boundary class, chi falling: keep climbing
        do_reset();
        set_all(16384, 0, 0);
        set_osc(0, 16384, 1, 15000);
        go(s);
        expect_at(s,      K_OMEGA, 0, 16384, "t3_seed");
        expect_at(s + 1,  K_OMEGA, 0, 16448, "t3_sw1");
        expect_at(s + 22, K_ADJ,   0, 1,     "t3_adj");
        expect_at(s + 27, K_ADJ,   0, 0,     "t3_adj_clr");
        expect_at(s + 27, K_SWEEP, 0, 1,     "t3_sweep");
        expect_at(s + 40, K_OMEGA, 0, 16512, "t3_sw2");
        expect_at(s + 40, K_OMEGA, 1, 16384, "t3_om1");
        until_cyc(s + 10);
        chi_packed[0 +: W] = W'(14000);
        until_cyc(s + 45);
        pulse_abort();
        drain();

        // chi rising reverses direction; quarter class halves the step
        do_reset();
        set_all(16384, 0, 0);
        set_osc(0, 16384, 1, 14000);
        go(s);
        expect_at(s + 1,  K_OMEGA, 0, 16448, "t4_sw1");
        expect_at(s + 29, K_OMEGA, 0, 16384, "t4_rev");
        expect_at(s + 49, K_ADJ,   0, 1,     "t4_adj2");
        expect_at(s + 56, K_OMEGA, 0, 16352, "t4_quarter");
        until_cyc(s + 10);
        chi_packed[0 +: W] = W'(15500);
        until_cyc(s + 40);
        position_class_packed[0 +: 2] = 2'b10;
        until_cyc(s + 60);
        pulse_abort();
        drain();

        // upper saturation, no wrap
        do_reset();
        set_all(16384, 0, 0);
        set_osc(0, 98294, 1, 500);
        go(s);
        expect_at(s + 1,  K_OMEGA, 0, 98304, "t5_clamp");
        expect_at(s + 22, K_ADJ,   0, 1,     "t5_adj");
        expect_at(s + 29, K_OMEGA, 0, 98304, "t5_clamp2");
        expect_at(s + 29, K_OMEGA, 1, 16384, "t5_om1");
        until_cyc(s + 32);
        pulse_abort();
        drain();

        // clk_en freeze, abort at idx 5, start+abort in IDLE ignored
        do_reset();
        for (int i = 0; i < N; i++) set_osc(i, 8192 + 256 * i, 1, 0);
        go(s);
        expect_at(s + 6,  K_OMEGA, 2, 8768,  "t6_om2");
        expect_at(s + 6,  K_OMEGA, 3, 8960,  "t6_frozen");
        expect_at(s + 6,  K_BUSY,  0, 1,     "t6_busy_frz");
        expect_at(s + 10, K_DONE,  0, 1,     "t6_done");
        expect_at(s + 10, K_BUSY,  0, 0,     "t6_busy");
        expect_at(s + 11, K_DONE,  0, 0,     "t6_done_end");
        expect_at(s + 11, K_OMEGA, 0, 8256,  "t6_om0");
        expect_at(s + 11, K_OMEGA, 4, 9280,  "t6_om4");
        expect_at(s + 11, K_OMEGA, 5, 9472,  "t6_om5");
        expect_at(s + 11, K_OMEGA, 20, 13312, "t6_om20");
        expect_at(s + 14, K_BUSY,  0, 0,     "t6_sa_busy");
        expect_at(s + 14, K_DONE,  0, 0,     "t6_sa_done");
        expect_at(s + 15, K_OMEGA, 0, 8256,  "t6_sa_om0");
        expect_at(s + 15, K_OMEGA, 5, 9472,  "t6_sa_om5");
        tick(3);
        clk_en = 1'b0;
        tick(4);
        clk_en = 1'b1;
        tick(2);
        pulse_abort();
        until_cyc(s + 13);
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        drain();

        // asynchronous reset mid-scan, then a normal run
        do_reset();
        set_all(16384, 1, 0);
        go(s);
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_busy", int'(busy), 0);
        check("t1_done", int'(done), 0);
        check("t1_omega_any", int'(|omega_dt_packed), 0);
        check("t1_sweep", int'(sweep_count), 0);
        check("t1_adj", int'(adj_count), 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        go(s);
        expect_at(s + 1, K_OMEGA, 0, 16448, "t1_run_om0");
        expect_at(s + 1, K_BUSY,  0, 1,     "t1_run_busy");
        expect_at(s + 3, K_ADJ,   0, 3,     "t1_run_adj");
        until_cyc(s + 5);
        pulse_abort();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
